// File: rtl/inv_lerp_if.sv
// Request/response bundle for inv_lerp: a valid/ready request carrying the endpoints and sample,
// and a valid/ready result carrying the ratio and status flags.
interface inv_lerp_if #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [INPUT_BITS-1:0]      ina;
  logic [INPUT_BITS-1:0]      inb;
  logic [INPUT_BITS-1:0]      value;
  logic                       out_valid;
  logic                       out_ready;
  logic [RATIO_FRAC_BITS-1:0] ratio;
  logic                       sat;
  logic                       div_zero;

  modport master (
    output in_valid, ina, inb, value, out_ready,
    input  in_ready, out_valid, ratio, sat, div_zero
  );

  modport slave (
    input  in_valid, ina, inb, value, out_ready,
    output in_ready, out_valid, ratio, sat, div_zero
  );
endinterface

// File: rtl/inv_lerp.sv
// Inverse lerp: ratio = (value - inb) * 2^F / (ina - inb) via a restoring divider, one bit per clock.
// Optional macro INV_LERP_ROUND_EN adds a guard bit and rounds the quotient half-up.
module inv_lerp #(
  parameter int INPUT_BITS      = 16,
  parameter int RATIO_FRAC_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  inv_lerp_if.slave  bus
);
  localparam int NW = INPUT_BITS + 1;
  localparam int F  = RATIO_FRAC_BITS;
`ifdef INV_LERP_ROUND_EN
  localparam int QW = F + 1;
`else
  localparam int QW = F;
`endif
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
  typedef enum logic [2:0] {CL_DZ, CL_ZERO, CL_OPP, CL_OVER, CL_DIV} cls_t;

  state_t state, state_nxt;
  logic   accept;
  logic   in_ready;
  logic   vld_p2;

  logic        [INPUT_BITS-1:0] ina_p0, inb_p0, value_p0;
  logic signed [NW-1:0]         num_p0, den_p0;
  logic        [NW-1:0]         num_mag, den_mag;
  cls_t                         cls;

  logic [NW-1:0] rem_p1, dvs_p1, trial, rem_nxt;
  logic          qbit;
  logic [QW-1:0] quo_p1, quo_nxt;
  logic [CW-1:0] cnt_p1;

  logic [F-1:0] ratio_p2;
  logic         sat_p2;
  logic         div_zero_p2;

  function automatic logic [NW-1:0] mag(input logic signed [NW-1:0] x);
    return x[NW-1] ? NW'(-x) : NW'(x);
  endfunction

  // Returns {sat, ratio} from the raw quotient.
  function automatic logic [F:0] finish_q(input logic [QW-1:0] q);
`ifdef INV_LERP_ROUND_EN
    if (&q) return {1'b1, {F{1'b1}}};
    return {1'b0, F'((q + QW'(1)) >> 1)};
`else
    return {1'b0, q};
`endif
  endfunction

  // Stage p0: signed deltas of the captured operands and special-case classification
  always_comb begin
    num_p0  = $signed({1'b0, value_p0}) - $signed({1'b0, inb_p0});
    den_p0  = $signed({1'b0, ina_p0})   - $signed({1'b0, inb_p0});
    num_mag = mag(num_p0);
    den_mag = mag(den_p0);
    if (den_p0 == '0)                         cls = CL_DZ;
    else if (num_p0 == '0)                    cls = CL_ZERO;
    else if (num_p0[NW-1] != den_p0[NW-1])    cls = CL_OPP;
    else if (num_mag >= den_mag)              cls = CL_OVER;
    else                                      cls = CL_DIV;
  end

  // Stage p1: restoring step; rem < dvs always holds, so the shift never overflows NW bits
  always_comb begin
    trial   = rem_p1 << 1;
    qbit    = (trial >= dvs_p1);
    rem_nxt = qbit ? (trial - dvs_p1) : trial;
    quo_nxt = (quo_p1 << 1) | QW'(qbit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)              state_nxt = PREP;
      PREP: state_nxt = (cls == CL_DIV) ? DIV : DONE;
      DIV:  if (cnt_p1 == '0)        state_nxt = DONE;
      DONE: if (bus.out_ready)       state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    vld_p2   = (state == DONE);
    accept   = bus.in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ina_p0   <= bus.ina;
      inb_p0   <= bus.inb;
      value_p0 <= bus.value;
    end
    if (state == PREP) begin
      rem_p1 <= num_mag;
      dvs_p1 <= den_mag;
      quo_p1 <= '0;
    end else if (state == DIV) begin
      rem_p1 <= rem_nxt;
      quo_p1 <= quo_nxt;
    end
  end

  // Stage p2: result registers, held stable throughout DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ratio_p2    <= '0;
      sat_p2      <= 1'b0;
      div_zero_p2 <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ratio_p2    <= '0;
          sat_p2      <= 1'b0;
          div_zero_p2 <= 1'b0;
        end
        PREP: begin
          cnt_p1 <= CW'(QW - 1);
          case (cls)
            CL_DZ:   div_zero_p2 <= 1'b1;
            CL_OPP:  sat_p2      <= 1'b1;
            CL_OVER: begin
              ratio_p2 <= '1;
              sat_p2   <= 1'b1;
            end
            default: ;
          endcase
        end
        DIV: begin
          cnt_p1 <= cnt_p1 - CW'(1);
          if (cnt_p1 == '0) {sat_p2, ratio_p2} <= finish_q(quo_nxt);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2;
  assign bus.ratio     = ratio_p2;
  assign bus.sat       = sat_p2;
  assign bus.div_zero  = div_zero_p2;
endmodule

// File: tb/tb_inv_lerp.sv
// Directed-vector bench for inv_lerp: a driver pushes hand-computed expectations into a queue and a
// negedge monitor pops and compares them when a result is handed off.
module tb_inv_lerp;
`ifdef INV_LERP_ROUND_EN
  localparam int LN = 10;
  localparam logic [7:0] R_7FFF = 8'h80;
  localparam logic       S_FFFE = 1'b1;
`else
  localparam int LN = 9;
  localparam logic [7:0] R_7FFF = 8'h7F;
  localparam logic       S_FFFE = 1'b0;
`endif

  typedef struct {
    logic [15:0] a, b, v;
    logic [7:0]  r;
    logic        s, z;
    int          lat;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   lat_meas = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  inv_lerp_if #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8)) bus ();

  inv_lerp #(.INPUT_BITS(16), .RATIO_FRAC_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, v, input logic [7:0] r,
                              input logic s, z, input int lat, input string nm);
    vec_t t;
    t.a = a; t.b = b; t.v = v; t.r = r; t.s = s; t.z = z; t.lat = lat; t.nm = nm;
    return t;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
  endtask

  // Issue one request; inputs are scrambled while the block is busy
  task automatic run(input vec_t t, input int stall, input bit push);
    int n;
    bit bad;
    wait_ready();
    bus.ina = t.a; bus.inb = t.b; bus.value = t.v;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    if (push) exp_q.push_back(t);
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    n = 0; bad = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) bad = 1;
      bus.ina = 16'($urandom); bus.inb = 16'($urandom); bus.value = 16'($urandom);
      @(posedge clk); #1; n++;
    end
    check({t.nm, "_busy_ready"}, {31'd0, bad}, 0);
    check({t.nm, "_out_valid"}, bus.out_valid, 1);
    if (stall > 0) begin
      bad = 0;
      repeat (stall) begin
        bus.ina = 16'($urandom); bus.inb = 16'($urandom); bus.value = 16'($urandom);
        if (!bus.out_valid || bus.in_ready || bus.ratio !== t.r || bus.sat !== t.s ||
            bus.div_zero !== t.z) bad = 1;
        @(posedge clk); #1;
      end
      check({t.nm, "_stall_stable"}, {31'd0, bad}, 0);
      bus.out_ready = 1'b1;
    end
    wait_ready();
  endtask

  initial begin : monitor
    logic prev_ov;
    vec_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !prev_ov) lat_meas = cyc - acc_cyc;
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", bus.out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.nm, "_ratio"},    bus.ratio,    e.r);
          check({e.nm, "_sat"},      bus.sat,      e.s);
          check({e.nm, "_div_zero"}, bus.div_zero, e.z);
          check({e.nm, "_latency"},  lat_meas,     e.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : driver
    vec_t t;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.ina = '0; bus.inb = '0; bus.value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ratio",     bus.ratio,     0);
    check("rst_sat",       bus.sat,       0);
    check("rst_div_zero",  bus.div_zero,  0);
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back(mk(16'hFFFF, 16'h0000, 16'h8000, 8'h80, 0, 0, LN, "half"));
    vecs.push_back(mk(16'hFFFF, 16'h0000, 16'h4000, 8'h40, 0, 0, LN, "quarter"));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 16'h7FFF, 8'h80, 0, 0, LN, "neg_deltas"));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 16'hFFFF, 8'h00, 0, 0, 1,  "num_zero"));
    vecs.push_back(mk(16'hFFFF, 16'h0000, 16'h7FFF, R_7FFF, 0, 0, LN, "just_under_half"));
    vecs.push_back(mk(16'hFFFF, 16'h0100, 16'hFFFF, 8'hFF, 1, 0, 1,  "at_ina"));
    vecs.push_back(mk(16'h1234, 16'h1234, 16'h5678, 8'h00, 0, 1, 1,  "div_zero"));
    vecs.push_back(mk(16'h8000, 16'h4000, 16'h1000, 8'h00, 1, 0, 1,  "below_inb"));
    vecs.push_back(mk(16'h0100, 16'h0000, 16'h00FF, 8'hFF, 0, 0, LN, "max_exact"));
    vecs.push_back(mk(16'hFFFF, 16'h0000, 16'hFFFE, 8'hFF, S_FFFE, 0, LN, "near_top"));
    vecs.push_back(mk(16'h1000, 16'h2000, 16'h0000, 8'hFF, 1, 0, 1,  "neg_over"));
    foreach (vecs[i]) run(vecs[i], 0, 1'b1);

    t = mk(16'hFFFF, 16'h0000, 16'h8000, 8'h80, 0, 0, LN, "stall");
    run(t, 20, 1'b1);

    // Abort mid-division with an asynchronous reset pulse
    wait_ready();
    bus.ina = 16'hFFFF; bus.inb = 16'h0000; bus.value = 16'h8000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready",  bus.in_ready,  1);
    @(posedge clk); #1;
    reset = 1'b0;

    t = mk(16'hFFFF, 16'h0000, 16'h8000, 8'h80, 0, 0, LN, "after_abort");
    run(t, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
